mult_arbiter: RTL and testbench

//   Shares one pipelined 16-bit multiplier (mult, MULT_LAT-stage start/done pipe) between N_REQ

---
 rtl/mult_pkg.sv | 10 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/mult_arbiter.sv | 115 +++++++++++
 tb/tb_mult_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared widths, default latency and the tag carried alongside each multiply.
package mult_pkg;
  localparam int unsigned MULT_W   = 16;
  localparam int unsigned MULT_LAT = 4;

  typedef struct packed {
    logic       v;
    logic [2:0] id;
  } mult_tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after ptr, wrapping around.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  int unsigned  cand;
  logic [IW-1:0] cand_i;

  always_comb begin
    gnt    = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = 0;
    cand_i = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand   = (32'(ptr) + k) % N;
      cand_i = IW'(cand);
      if (!any && req[cand_i]) begin
        any         = 1'b1;
        gnt[cand_i] = 1'b1;
        idx         = cand_i;
      end
    end
  end
endmodule

// File: rtl/mult_arbiter.sv
// Shares one fixed-latency pipelined multiplier among N_REQ requesters with
// round-robin issue, tag tracking through the pipe and per-requester result holding.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned MULT_LAT = mult_pkg::MULT_LAT,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*MULT_W-1:0]   req_mcand,
  input  logic [N_REQ*MULT_W-1:0]   req_mplier,
  output logic [N_REQ-1:0]          rsp_valid,
  input  logic [N_REQ-1:0]          rsp_ready,
  output logic [N_REQ*MULT_W-1:0]   rsp_product,
  output logic                      mult_start,
  output logic [MULT_W-1:0]         mult_mcand,
  output logic [MULT_W-1:0]         mult_mplier,
  input  logic [MULT_W-1:0]         mult_product,
  input  logic                      mult_done,
  output logic                      err_tag,
  output logic [CNT_W-1:0]          issue_count
);
  localparam int unsigned IW = $clog2(N_REQ);

  logic [N_REQ-1:0] busy;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] accept;
  logic [N_REQ-1:0] pop_set;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    gnt_idx;
  logic [IW-1:0]    issue_id;
  logic [IW-1:0]    pop_idx;
  logic             gnt_any;
  mult_tag_t        tag_pipe [MULT_LAT];
  mult_tag_t        pop_tag;

  // Grants are held off while reset is asserted so req_ready reads 0 like every other output.
  assign elig = req_valid & ~busy & {N_REQ{reset_n}};

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr (
    .req (elig),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign req_ready = gnt;
  assign accept    = rsp_valid & rsp_ready;
  assign pop_tag   = tag_pipe[MULT_LAT-1];
  assign pop_idx   = IW'(pop_tag.id);

  always_comb begin
    pop_set = '0;
    if (pop_tag.v) pop_set[pop_idx] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr         <= IW'(N_REQ - 1);
      issue_id    <= '0;
      mult_start  <= 1'b0;
      mult_mcand  <= '0;
      mult_mplier <= '0;
      issue_count <= '0;
    end else begin
      mult_start <= gnt_any;
      issue_id   <= gnt_idx;
      if (gnt_any) begin
        ptr         <= gnt_idx;
        issue_count <= issue_count + 1'b1;
        mult_mcand  <= req_mcand[MULT_W*gnt_idx +: MULT_W];
        mult_mplier <= req_mplier[MULT_W*gnt_idx +: MULT_W];
      end else begin
        mult_mcand  <= '0;
        mult_mplier <= '0;
      end
    end
  end

  // The tag enters alongside mult_start, so the last stage lines up with mult_done.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < MULT_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= '{v: mult_start, id: (mult_start ? 3'(issue_id) : 3'd0)};
      for (int unsigned i = 1; i < MULT_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy        <= '0;
      rsp_valid   <= '0;
      rsp_product <= '0;
      err_tag     <= 1'b0;
    end else begin
      busy      <= (busy & ~accept) | gnt;
      rsp_valid <= (rsp_valid & ~accept) | pop_set;
      if (pop_tag.v) rsp_product[MULT_W*pop_idx +: MULT_W] <= mult_product;
      if (pop_tag.v != mult_done) err_tag <= 1'b1;
    end
  end

  a_pop_while_held: assert property (@(posedge clock) disable iff (!reset_n)
    !(pop_tag.v && rsp_valid[pop_idx]));
endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: behavioural multiplier, rr/busy model and a result scoreboard.
module tb_mult_arbiter;
  localparam int unsigned N   = 4;
  localparam int unsigned LAT = 4;
  localparam int unsigned W   = 16;
  localparam int unsigned CW  = 32;

  typedef struct {
    int         id;
    logic [W-1:0] prod;
    int         cyc;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0]   req_mcand, req_mplier, rsp_product;
  logic             mult_start, mult_done, err_tag;
  logic [W-1:0]     mult_mcand, mult_mplier, mult_product;
  logic [CW-1:0]    issue_count;

  int               n_vec = 0;
  int               n_err = 0;
  int               cyc = 0;
  exp_t             sb [$];
  logic [2*W-1:0]   ops [N][$];
  int               glog [$];
  logic [N-1:0]     busy_m, seen;
  logic [W-1:0]     held [N];
  int               hold [N];
  int               exp_ptr;
  logic [CW-1:0]    exp_cnt;
  logic             prev_hs, exp_err, fault_req;
  logic [W-1:0]     prev_mc, prev_mp;

  always #5 clock = ~clock;

  mult_arbiter #(
    .N_REQ    (N),
    .MULT_LAT (LAT),
    .CNT_W    (CW)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_mcand    (req_mcand),
    .req_mplier   (req_mplier),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_product  (rsp_product),
    .mult_start   (mult_start),
    .mult_mcand   (mult_mcand),
    .mult_mplier  (mult_mplier),
    .mult_product (mult_product),
    .mult_done    (mult_done),
    .err_tag      (err_tag),
    .issue_count  (issue_count)
  );

  // Behavioural multiplier: done and product LAT cycles after start, reset from the same source.
  logic [LAT-1:0] m_v;
  logic [W-1:0]   m_p [LAT];
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_v <= '0;
      for (int i = 0; i < int'(LAT); i++) m_p[i] <= '0;
    end else begin
      m_v    <= {m_v[LAT-2:0], mult_start};
      m_p[0] <= mult_mcand * mult_mplier;
      for (int i = 1; i < int'(LAT); i++) m_p[i] <= m_p[i-1];
    end
  end
  assign mult_done    = m_v[LAT-1] | fault_req;
  assign mult_product = m_p[LAT-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc, got, want);
    end
  endtask

  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] e, input int p);
    logic [N-1:0] g;
    g = '0;
    for (int k = 1; k <= int'(N); k++) begin
      if (e[(p + k) % N]) begin
        g[(p + k) % N] = 1'b1;
        break;
      end
    end
    return g;
  endfunction

  task automatic clear_model();
    sb.delete();
    glog.delete();
    for (int i = 0; i < int'(N); i++) begin
      ops[i].delete();
      hold[i] = 0;
      held[i] = '0;
    end
    busy_m    = '0;
    seen      = '0;
    exp_ptr   = N - 1;
    exp_cnt   = '0;
    prev_hs   = 1'b0;
    prev_mc   = '0;
    prev_mp   = '0;
    exp_err   = 1'b0;
    fault_req = 1'b0;
    cyc       = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < int'(N); i++) begin
      req_valid[i]         = (ops[i].size() > 0);
      req_mcand[W*i +: W]  = req_valid[i] ? ops[i][0][2*W-1:W] : '0;
      req_mplier[W*i +: W] = req_valid[i] ? ops[i][0][W-1:0]   : '0;
      rsp_ready[i]         = (hold[i] == 0);
    end
  endtask

  // Called one time unit before the rising edge; checks outputs, then advances the model.
  task automatic sample();
    logic [N-1:0]   hs, acc, exp_rdy;
    logic [2*W-1:0] op;
    logic [W-1:0]   p;
    exp_t           e;
    exp_rdy = rr_pick(req_valid & ~busy_m, exp_ptr);
    check("req_ready",   64'(req_ready),   64'(exp_rdy));
    check("mult_start",  64'(mult_start),  64'(prev_hs));
    check("mult_mcand",  64'(mult_mcand),  64'(prev_mc));
    check("mult_mplier", 64'(mult_mplier), 64'(prev_mp));
    check("issue_count", 64'(issue_count), 64'(exp_cnt));
    check("err_tag",     64'(err_tag),     64'(exp_err));
    for (int i = 0; i < int'(N); i++) begin
      if (rsp_valid[i] && !seen[i]) begin
        if (sb.size() == 0) begin
          check($sformatf("rsp_unexpected[%0d]", i), 64'(rsp_valid[i]), 64'(0));
        end else begin
          e = sb.pop_front();
          check("rsp_id",      64'(i), 64'(e.id));
          check("rsp_product", 64'(rsp_product[W*i +: W]), 64'(e.prod));
          check("rsp_latency", 64'(cyc - e.cyc), 64'(LAT + 2));
        end
        seen[i] = 1'b1;
        held[i] = rsp_product[W*i +: W];
      end else if (rsp_valid[i]) begin
        check($sformatf("rsp_hold[%0d]", i), 64'(rsp_product[W*i +: W]), 64'(held[i]));
      end else if (seen[i]) begin
        check($sformatf("rsp_drop[%0d]", i), 64'(rsp_valid[i]), 64'(1));
      end
    end

    hs  = req_valid & req_ready;
    acc = rsp_valid & rsp_ready;
    prev_hs = 1'b0;
    prev_mc = '0;
    prev_mp = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (hs[i]) begin
        op = ops[i].pop_front();
        p  = op[2*W-1:W] * op[W-1:0];
        sb.push_back('{id: i, prod: p, cyc: cyc});
        glog.push_back(i);
        busy_m[i] = 1'b1;
        exp_ptr   = i;
        exp_cnt   = exp_cnt + 1'b1;
        prev_hs   = 1'b1;
        prev_mc   = op[2*W-1:W];
        prev_mp   = op[W-1:0];
      end
      if (hold[i] > 0) hold[i]--;
    end
    busy_m = busy_m & ~acc;
    seen   = seen & ~acc;
    if (fault_req) exp_err = 1'b1;
    cyc++;
  endtask

  task automatic cycle();
    drive();
    #4;
    sample();
    @(negedge clock);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_req_ready"},   64'(req_ready),   64'(0));
    check({tag, "_rsp_valid"},   64'(rsp_valid),   64'(0));
    check({tag, "_rsp_product"}, 64'(rsp_product), 64'(0));
    check({tag, "_mult_start"},  64'(mult_start),  64'(0));
    check({tag, "_mult_mcand"},  64'(mult_mcand),  64'(0));
    check({tag, "_mult_mplier"}, 64'(mult_mplier), 64'(0));
    check({tag, "_err_tag"},     64'(err_tag),     64'(0));
    check({tag, "_issue_count"}, 64'(issue_count), 64'(0));
  endtask

  // Entered at a falling edge; reset is asserted mid-phase, away from any clock edge.
  task automatic do_reset(input string tag);
    #2 reset_n = 1'b0;
    #1 reset_check(tag);
    clear_model();
  endtask

  task automatic release_reset();
    drive();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    clear_model();
    ops[0].push_back({16'd3, 16'd5});
    drive();
    #3 reset_check("init");
    @(negedge clock);
    reset_n = 1'b1;
    run(10);
    check("single_count", 64'(issue_count), 64'(1));

    do_reset("burst_rst");
    ops[0].push_back({16'hFFFF, 16'hFFFF});
    ops[1].push_back({16'h0100, 16'h0100});
    ops[2].push_back({16'h1234, 16'h0003});
    ops[3].push_back({16'h00FF, 16'h0101});
    release_reset();
    run(14);
    for (int k = 0; k < 4; k++) check("burst_order", 64'(glog[k]), 64'(k));

    for (int i = 0; i < int'(N); i++)
      for (int k = 0; k < ((i == 1) ? 2 : 4); k++)
        ops[i].push_back({16'($urandom), 16'($urandom)});
    hold[1] = 18;
    run(45);

    do_reset("fair_rst");
    for (int k = 0; k < 6; k++) begin
      ops[0].push_back({16'($urandom), 16'($urandom)});
      ops[2].push_back({16'($urandom), 16'($urandom)});
    end
    release_reset();
    run(50);
    check("fair_grants", 64'(glog.size()), 64'(12));
    for (int k = 0; k < glog.size(); k++)
      check("fair_order", 64'(glog[k]), 64'((k % 2 == 0) ? 0 : 2));

    for (int i = 1; i < int'(N); i++) ops[i].push_back({16'($urandom), 16'($urandom)});
    run(3);
    check("flight_count", 64'(issue_count), 64'(15));
    do_reset("flight_rst");
    release_reset();
    run(12);

    fault_req = 1'b1;
    cycle();
    fault_req = 1'b0;
    run(8);
    check("fault_err_sticky", 64'(err_tag), 64'(1));
    check("fault_no_rsp",     64'(rsp_valid), 64'(0));
    check("sb_drained",       64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
